ffo_p: RTL and testbench
========================

FFO_P -- requirements
Module: ffo_p

Interface
REQ-001 Parameter: N, default 32, width of the search vector; N is a power of two, N >= 2.
REQ-002 Derived constant: W = clog2(N), width of the position output; not user-overridable.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: b  input  N  search vector, ascending numbering [0:N-1]; b[0] is the leftmost (MSB) bit, b[N-1] the rightmost (LSB) bit.
REQ-006 Port: v  output  1  valid flag; 1 when the sampled b contains at least one bit equal to 1.
REQ-007 Port: p  output  W  position, ascending numbering [0:W-1]; index of the found bit.

Function
REQ-008 Search rule: p SHALL be the largest index i such that b[i]==1. This is the first 1 found when scanning from b[N-1] toward b[0].
REQ-009 Bits at indices below the found bit, including X/unknown values, SHALL NOT affect p or v.
REQ-010 v SHALL be the OR-reduction of b.
REQ-011 When b contains no 1 (all zero), v SHALL be 0 and p SHALL be 0.
REQ-012 Latency: v and p SHALL be registered. Both reflect the b value sampled at rising edge k and are valid after that edge. This is one cycle of latency, and a new result is produced every cycle.
REQ-013 No handshake: b is sampled unconditionally on every rising edge when rst is 0.
REQ-014 v and p SHALL always update together from the same sampled b; no intermediate mixing of old and new values.
REQ-015 Search logic: combinational priority tree of depth log2(N), parameterised for any legal N; no linear ripple chain.
REQ-016 Width rule: p holds values 0..N-1 exactly; no truncation or wrap for any legal N.
REQ-017 No other internal state.

Reset
REQ-018 While rst is 1 at a rising edge, v SHALL be 0 and p SHALL be 0 after that edge.
REQ-019 rst SHALL take priority over b sampling at the same edge.
REQ-020 Deasserting rst: the first edge with rst=0 samples b normally, and a result is available after that edge.
REQ-021 Asserting rst mid-stream discards the in-flight result; there is no asynchronous effect.

Verification
REQ-022 The bench SHALL use N=32, apply reset for 2 cycles, and check every output one cycle after driving b.
REQ-023 Reset: rst=1 with b=32'hFFFFFFFF -> v=0, p=0 after the edge.
REQ-024 Walking one: for each i=0..31, drive only b[i]=1 -> v=1, p=i.
REQ-025 All ones: b=32'hFFFFFFFF -> v=1, p=31. All zero: b=0 -> v=0, p=0.
REQ-026 Multiple ones: b[5]=b[20]=1, others 0 -> v=1, p=20.
REQ-027 Don't-care prefix: b[0..30]=X, b[31]=1 -> v=1, p=31.
REQ-028 Shift sequence: start with b[31]=1, shift b right by 1 (toward b[31]) each cycle -> p=31 while b[31]=1, then v=0 once all bits are 0.
REQ-029 Reset mid-stream: b=1 at index 7, assert rst for one edge -> v=0, p=0. Release rst -> v=1, p=7 one cycle later.
REQ-030 Random: at least 1000 random b values, compared each cycle against a reference model (largest set index, v=|b).

Source files
------------

// File: rtl/ffo_p.sv
// Find-first-one from the right: registered position of the highest-index set bit
// of b, where b[0] is the leftmost bit, plus a valid flag. The search is a
// log2(N)-deep binary priority tree, and the result has one cycle of latency.
module ffo_p #(
  parameter  int unsigned N = 32,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:N-1] b,
  output logic         v,
  output logic [0:W-1] p
);

  // Tree level l has N>>l nodes. Node k covers b[k*2^l +: 2^l].
  // Each node carries a valid bit and the offset of the winning bit within
  // the range it covers. The offset is kept at the full W width, and only its
  // low l bits can be nonzero.
  for (genvar l = 0; l <= W; l++) begin : g_lvl
    localparam int unsigned NODES = N >> l;

    logic [NODES-1:0] v_c;
    logic [W-1:0]     p_c [NODES];

    if (l == 0) begin : g_leaf
      // Leaves: each bit of b is its own one-bit node.
      for (genvar k = 0; k < NODES; k++) begin : g_bit
        assign v_c[k] = b[k];
        assign p_c[k] = '0;
      end
    end else begin : g_node
      // The right child covers the higher indices, so it wins whenever it is valid.
      // Lower-index bits (even X) then never reach the output.
      localparam logic [W-1:0] RIGHT_OFS = W'(1) << (l - 1);

      for (genvar k = 0; k < NODES; k++) begin : g_pair
        assign v_c[k] = g_lvl[l-1].v_c[2*k+1] | g_lvl[l-1].v_c[2*k];
        assign p_c[k] = g_lvl[l-1].v_c[2*k+1]
                      ? (g_lvl[l-1].p_c[2*k+1] | RIGHT_OFS)
                      : g_lvl[l-1].p_c[2*k];
      end
    end
  end

  logic         v_d;
  logic         v_q;
  logic [W-1:0] p_d;
  logic [W-1:0] p_q;

  // Next result comes from the tree root. The position is forced to 0 when no bit is set.
  always_comb begin
    v_d = 1'b0;
    p_d = '0;
    v_d = g_lvl[W].v_c[0];
    if (v_d) begin
      p_d = g_lvl[W].p_c[0];
    end
  end

  // Result register. Valid and position update together, and reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      p_q <= '0;
    end else begin
      v_q <= v_d;
      p_q <= p_d;
    end
  end

  assign v = v_q;
  assign p = p_q;

endmodule

// File: tb/tb_ffo_p.sv
// Self-checking bench for ffo_p (N=32): directed vectors, multi-cycle
// corner sequences and randomized vectors against a reference model.
module tb_ffo_p;

  localparam int unsigned N = 32;
  localparam int unsigned W = 5;

  logic         clk;
  logic         rst;
  logic [0:N-1] b;
  logic         v;
  logic [0:W-1] p;

  int n_cmp = 0;
  int n_err = 0;

  ffo_p #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .b  (b),
    .v  (v),
    .p  (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [0:N-1] b;
    logic         ev;
    logic [W-1:0] ep;
  } vec_t;

  // Reference: scan from the rightmost index toward index 0 and stop at the first 1.
  function automatic void ref_ffo(input logic [0:N-1] bb, output logic ev, output logic [W-1:0] ep);
    ev = 1'b0;
    ep = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bb[i] === 1'b1) begin
        ev = 1'b1;
        ep = W'(i);
        return;
      end
    end
  endfunction

  task automatic check(input string name, input logic ev, input logic [W-1:0] ep);
    logic [W-1:0] pv;
    pv = p;
    n_cmp++;
    if (v !== ev || pv !== ep) begin
      n_err++;
      $display("FAIL %s: got v=%b p=%0d, expected v=%b p=%0d", name, v, pv, ev, ep);
    end
  endtask

  // Drive b and rst away from the active edge, clock once, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic [0:N-1] bv);
    @(negedge clk);
    rst = r;
    b   = bv;
    @(posedge clk);
    #1;
  endtask

  vec_t         vecs[$];
  logic [0:N-1] bv;
  logic         mv;
  logic [W-1:0] mp;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    b   = '1;

    // Reset held for two edges with all ones on b.
    step(1'b1, '1);
    check("reset_edge1", 1'b0, 5'd0);
    step(1'b1, '1);
    check("reset_edge2", 1'b0, 5'd0);

    // Directed table.
    vecs.push_back('{"all_ones", 32'hFFFF_FFFF, 1'b1, 5'd31});
    vecs.push_back('{"all_zero", 32'h0000_0000, 1'b0, 5'd0});
    bv = '0; bv[5] = 1'b1; bv[20] = 1'b1;
    vecs.push_back('{"multi_5_20", bv, 1'b1, 5'd20});
    bv = {{31{1'bx}}, 1'b1};
    vecs.push_back('{"x_prefix", bv, 1'b1, 5'd31});
    bv = '0; bv[0] = 1'b1; bv[1] = 1'b1;
    vecs.push_back('{"left_pair", bv, 1'b1, 5'd1});
    for (int i = 0; i < N; i++) begin
      bv = '0;
      bv[i] = 1'b1;
      vecs.push_back('{$sformatf("walk_%0d", i), bv, 1'b1, W'(i)});
    end
    foreach (vecs[i]) begin
      step(1'b0, vecs[i].b);
      check(vecs[i].name, vecs[i].ev, vecs[i].ep);
    end

    // Shift toward b[31]: the position stays at 31 while b[31] is set, then v drops once b is all zero.
    bv = 32'hF0F0_F0F1;
    for (int c = 0; c < N + 2; c++) begin
      step(1'b0, bv);
      ref_ffo(bv, mv, mp);
      check($sformatf("shift_%0d", c), mv, mp);
      bv = bv >> 1;
    end

    // Reset mid-stream discards the result. Release gives a result after one edge.
    bv = '0; bv[7] = 1'b1;
    step(1'b0, bv);
    check("mid_pre", 1'b1, 5'd7);
    step(1'b1, bv);
    check("mid_rst", 1'b0, 5'd0);
    step(1'b0, bv);
    check("mid_release", 1'b1, 5'd7);

    // Back-to-back changes: every cycle produces a fresh result with no carry-over.
    bv = '0; bv[3] = 1'b1;
    step(1'b0, bv);
    check("b2b_3", 1'b1, 5'd3);
    step(1'b0, '0);
    check("b2b_zero", 1'b0, 5'd0);
    bv = '0; bv[30] = 1'b1;
    step(1'b0, bv);
    check("b2b_30", 1'b1, 5'd30);

    // Randomized vectors, with some sparse ones and some all-zero ones.
    for (int c = 0; c < 1200; c++) begin
      case ($urandom_range(3))
        0:       bv = $urandom;
        1:       bv = $urandom & $urandom & $urandom;
        2:       bv = ($urandom_range(7) == 0) ? '0 : (32'h1 << $urandom_range(31));
        default: bv = $urandom & $urandom & $urandom & $urandom & $urandom;
      endcase
      step(1'b0, bv);
      ref_ffo(bv, mv, mp);
      check($sformatf("rand_%0d", c), mv, mp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
